// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder with IDLE/RUN/DONE control: one full-adder cell, LSB first.
// Optional subtract mode (sub port, a - b via ~b and carry-in 1) when SERIAL_ADDER_SUB_EN is defined.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic [WIDTH-1:0] op_b;
    logic             op_c;
    logic             fa_s, fa_co;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is a + ~b + 1; cin is ignored in that mode.
    assign op_b = sub ? ~b : b;
    assign op_c = sub ? 1'b1 : cin;
`else
    assign op_b = b;
    assign op_c = cin;
`endif

    assign fa_s  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign fa_co = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = op_b;
                    carry_d = op_c;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_q + 1'b1;
                // cout only moves on the final bit so it keeps the last result otherwise
                if (cnt_q == CNT_LAST) begin
                    cout_d  = fa_co;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=4): arithmetic model checked every cycle
// plus directed literal expectations; covers subtract mode when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_ctrl;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .a(a),
        .b(b),
        .cin(cin),
        .busy(busy),
        .done(done),
        .sum(sum),
        .cout(cout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a pending result becomes visible W edges after the accepting edge.
    int           run_left = 0;
    bit           m_done = 0;
    bit           m_valid = 0;
    bit           model_live = 0;
    logic [W-1:0] m_sum = '0;
    bit           m_cout = 0;
    int           pend = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            model_live = 1;
            run_left   = 0;
            m_done     = 0;
            m_valid    = 1;
            m_sum      = '0;
            m_cout     = 0;
        end else if (run_left > 0) begin
            run_left--;
            if (run_left == 0) begin
                m_done  = 1;
                m_valid = 1;
                m_sum   = pend[W-1:0];
                m_cout  = pend[W];
            end
        end else begin
            m_done = 0;
            if (start) begin
`ifdef SERIAL_ADDER_SUB_EN
                if (sub) pend = int'(a) + int'((~b) & 4'hF) + 1;
                else     pend = int'(a) + int'(b) + int'(cin);
`else
                pend = int'(a) + int'(b) + int'(cin);
`endif
                run_left = W;
                m_valid  = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("busy", {31'b0, busy}, {31'b0, run_left > 0});
            check("done", {31'b0, done}, {31'b0, m_done});
            if (m_valid) begin
                check("sum", {28'b0, sum}, {28'b0, m_sum});
                check("cout", {31'b0, cout}, {31'b0, m_cout});
            end
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Operands are scrambled after acceptance to show they are only captured on the accepting edge.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          input logic [W-1:0] es, input logic ec, input string nm);
        int lat;
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~ta; b = ~tb_v; cin = ~tc;
        wait_done(lat);
        check({nm, " latency"}, lat + 1, 5);
        check({nm, " sum"}, {28'b0, sum}, {28'b0, es});
        check({nm, " cout"}, {31'b0, cout}, {31'b0, ec});
    endtask

    initial begin
        int t1, t2, n;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset busy", {31'b0, busy}, 0);
        check("reset done", {31'b0, done}, 0);
        check("reset sum", {28'b0, sum}, 0);
        check("reset cout", {31'b0, cout}, 0);
        rst = 1'b0;

        run_op(4'h5, 4'h3, 1'b0, 4'h8, 1'b0, "add5_3");
        @(negedge clk);
        @(negedge clk);
        check("add5_3 hold sum", {28'b0, sum}, 32'h8);
        check("add5_3 hold done", {31'b0, done}, 0);

        run_op(4'hF, 4'hF, 1'b1, 4'hF, 1'b1, "allones");
        run_op(4'hF, 4'h0, 1'b1, 4'h0, 1'b1, "wrap");

        // Back-to-back with start held, then toggled during RUN.
        @(negedge clk);
        a = 4'h1; b = 4'h2; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 4'h6; b = 4'h6;
        wait_done(n);
        t1 = cyc;
        check("b2b first sum", {28'b0, sum}, 32'h3);
        check("b2b first cout", {31'b0, cout}, 0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        t2 = cyc;
        check("b2b spacing", t2 - t1, 5);
        check("b2b second sum", {28'b0, sum}, 32'hC);
        check("b2b second cout", {31'b0, cout}, 0);

        // Reset on the 2nd RUN edge aborts the operation.
        @(negedge clk);
        a = 4'h9; b = 4'h9; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", {31'b0, busy}, 0);
        check("abort done", {31'b0, done}, 0);
        check("abort sum", {28'b0, sum}, 0);
        check("abort cout", {31'b0, cout}, 0);
        run_op(4'h2, 4'h2, 1'b0, 4'h4, 1'b0, "after_abort");

`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b1;
        run_op(4'h3, 4'h5, 1'b0, 4'hE, 1'b0, "sub3_5");
        run_op(4'h7, 4'h2, 1'b0, 4'h5, 1'b1, "sub7_2");
        sub = 1'b0;
`endif

        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
